// File: rtl/verificador_paridad_pkg.sv
// Shared state encodings, error-counter type and saturation helper for the serial parity checker.
package verificador_paridad_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0] ERR_MAX = 8'd255;

  typedef logic [7:0] err_cnt_t;

  // Holds at ERR_MAX instead of wrapping back to zero.
  function automatic err_cnt_t sat_inc(input err_cnt_t c);
    return (c < ERR_MAX) ? c + 8'd1 : c;
  endfunction

endpackage

// File: rtl/verificador_paridad_if.sv
// Serial frame input and per-frame result bundle between the bit source and the parity checker.
interface verificador_paridad_if #(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 busy;
  logic                 done;
  logic                 par_err;
  logic [DATA_BITS-1:0] data_out;
  logic [7:0]           err_count;

  modport master (
    output start, bit_in, bit_valid,
    input  busy, done, par_err, data_out, err_count
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output busy, done, par_err, data_out, err_count
  );
endinterface

// File: rtl/acumulador_xor.sv
// 1-bit XOR accumulator: synchronous active-low reset, load of an init value, enable folds i_d in.
module acumulador_xor #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_init,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_init;
    end else if (i_en) begin
      r_q <= r_q ^ i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/verificador_paridad.sv
// Serial parity checker: start strobe, DATA_BITS data bits LSB first, one parity bit.
// done is high during the cycle after the parity bit is sampled; start is honoured in every state.
module verificador_paridad
  import verificador_paridad_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  verificador_paridad_if.slave  bus
);

  localparam int   CNT_W    = $clog2(DATA_BITS);
  localparam logic ACC_INIT = (PARITY_ODD != 0);

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_par_err;
  err_cnt_t             r_err_count;

  logic w_acc;
  logic w_acc_en;
  logic w_frame_err;
  logic w_last_bit;

  // A bit_valid coinciding with start belongs to no frame, so it never reaches the accumulator.
  assign w_acc_en    = (r_state == ST_DATA) && bus.bit_valid && !bus.start;
  assign w_frame_err = w_acc ^ bus.bit_in;
  assign w_last_bit  = (r_cnt == CNT_W'(DATA_BITS - 1));

  acumulador_xor #(
    .RST_VAL (ACC_INIT)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (bus.start),
    .i_init (ACC_INIT),
    .i_en   (w_acc_en),
    .i_d    (bus.bit_in),
    .o_q    (w_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_data_out  <= '0;
      r_par_err   <= 1'b0;
      r_err_count <= '0;
    end else if (bus.start) begin
      r_state <= ST_DATA;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        ST_DATA: begin
          if (bus.bit_valid) begin
            r_shift <= {bus.bit_in, r_shift[DATA_BITS-1:1]};
            r_cnt   <= r_cnt + 1'b1;
            if (w_last_bit) begin
              r_state <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (bus.bit_valid) begin
            r_par_err  <= w_frame_err;
            r_data_out <= r_shift;
            if (w_frame_err) begin
              r_err_count <= sat_inc(r_err_count);
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (r_state == ST_DATA) || (r_state == ST_PARITY);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.par_err   = r_par_err;
  assign bus.data_out  = r_data_out;
  assign bus.err_count = r_err_count;

endmodule
